// File: rtl/audio_sample_player.sv
// Sample-rate paced ROM walker with start/stop/loop control and a registered sample.
// Define AUDIO_DSM_EN to build the first-order delta-sigma DAC on dac_out.
module audio_sample_player #(
  parameter int unsigned CLK_DIV   = 3125,
  parameter int unsigned LAST_ADDR = 16383
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [13:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        done,
  output logic        dac_out
);

  typedef enum logic {
    IDLE,
    PLAY
  } state_e;

  localparam logic [15:0] CNT_MAX  = 16'(CLK_DIV - 1);
  localparam logic [13:0] ADDR_MAX = 14'(LAST_ADDR);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [13:0] addr_q;
  logic [15:0] sample_q;
  logic        valid_q;
  logic        done_q;
  logic        tick;

  assign tick = (cnt_q == CNT_MAX);

  // Priority inside PLAY: stop, then start, then the divider tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q <= PLAY;
            addr_q  <= '0;
            cnt_q   <= '0;
          end
        end
        PLAY: begin
          if (stop) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
          end else if (start) begin
            addr_q <= '0;
            cnt_q  <= '0;
          end else if (tick) begin
            cnt_q    <= '0;
            sample_q <= rom_data;
            valid_q  <= 1'b1;
            if (addr_q != ADDR_MAX) begin
              addr_q <= addr_q + 14'd1;
            end else begin
              addr_q <= '0;
              if (!loop_en) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q == PLAY);
  assign done         = done_q;

`ifdef AUDIO_DSM_EN
  logic [15:0] acc_q;
  logic        dac_q;
  logic [16:0] sum_d;

  // Offset-binary input: the carry density tracks (sample + 32768) / 65536.
  assign sum_d = {1'b0, acc_q} + {1'b0, sample_q ^ 16'h8000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dac_q <= 1'b0;
    end else begin
      acc_q <= sum_d[15:0];
      dac_q <= sum_d[16];
    end
  end

  assign dac_out = dac_q;
`else
  assign dac_out = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_player.sv
// Bench for audio_sample_player: directed steps plus random control traffic,
// checked against a playback-time model (CLK_DIV=4, LAST_ADDR=7).
module tb_audio_sample_player;

  localparam int DIV  = 4;
  localparam int NSMP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [13:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        dac_out;

  int vectors = 0;
  int miscompares = 0;
  bit rom_hi = 1'b0;

  // model: playback time since the (re)start edge
  bit          m_play = 1'b0;
  int          m_t = 0;
  logic [15:0] m_sample = '0;
  bit          m_valid = 1'b0;
  bit          m_done = 1'b0;
  int          m_idx = -1;

  audio_sample_player #(.CLK_DIV(DIV), .LAST_ADDR(NSMP - 1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample(sample), .sample_valid(sample_valid), .busy(busy),
    .done(done), .dac_out(dac_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input int a);
    return rom_hi ? 16'h7FFF : 16'(16'h1000 + a);
  endfunction

  always_comb rom_data = rom_val(int'(rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_t = 0; m_sample = '0;
    m_valid = 0; m_done = 0; m_idx = -1;
  endtask

  task automatic check_all();
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("sample", 32'(sample), 32'(m_sample));
    chk("busy", 32'(busy), 32'(m_play));
    chk("done", 32'(done), 32'(m_done));
    chk("rom_addr", 32'(rom_addr),
        m_play ? 32'((m_t / DIV) % NSMP) : 32'd0);
`ifndef AUDIO_DSM_EN
    chk("dac_out", 32'(dac_out), 32'd0);
`endif
  endtask

  // One clock: apply inputs, advance the model on the edge, check #1 later.
  task automatic step(input bit s, input bit p, input bit l);
    start = s; stop = p; loop_en = l;
    @(posedge clk);
    m_valid = 0; m_done = 0; m_idx = -1;
    if (p && m_play) begin
      m_play = 0; m_t = 0; m_sample = '0;
    end else if (s && !p) begin
      m_play = 1; m_t = 0;
    end else if (m_play) begin
      m_t++;
      if (m_t % DIV == 0) begin
        m_idx = (m_t / DIV - 1) % NSMP;
        m_sample = rom_val(m_idx);
        m_valid = 1;
        if (m_idx == NSMP - 1 && !l) begin
          m_play = 0; m_t = 0; m_done = 1;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit l);
    for (int i = 0; i < n; i++) step(0, 0, l);
  endtask

  task automatic run_to(input int idx, input bit l);
    int k = 0;
    do begin
      step(0, 0, l);
      k++;
    end while (m_idx != idx && k < 100);
    chk("strobe_reached", 32'(m_idx == idx), 32'd1);
  endtask

  initial begin
    int ones;
    #2;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_dac", 32'(dac_out), 32'd0);
    #5 rst_n = 1'b1;

`ifdef AUDIO_DSM_EN
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0);
      chk("dsm_half", 32'(dac_out), 32'(k % 2 == 0));
    end
`else
    idle(3, 0);
`endif

    // full non-looping clip
    step(1, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0);
      if (k % DIV == 0 && k <= 32)
        chk("strobe_timing", 32'(sample_valid), 32'd1);
      if (k == 32) chk("done_last", 32'(done), 32'd1);
    end

    // looping through the clip end
    step(1, 0, 1);
    idle(40, 1);
    chk("loop_busy", 32'(busy), 32'd1);

    // stop two cycles after the 1003 strobe
    step(1, 0, 0);
    run_to(3, 0);
    idle(2, 0);
    step(0, 1, 0);
    idle(10, 0);

    // restart two cycles after the 1002 strobe
    step(1, 0, 0);
    run_to(2, 0);
    idle(2, 0);
    step(1, 0, 0);
    for (int k = 1; k <= DIV; k++) step(0, 0, 0);
    chk("restart_strobe", 32'(sample), 32'h1000);
    idle(6, 0);

    // start and stop together in PLAY
    step(0, 1, 1);
    step(1, 0, 0);
    idle(5, 0);
    step(1, 1, 0);
    idle(6, 0);
    step(1, 1, 0);
    idle(3, 0);

    // random control traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(39) == 0, $urandom_range(59) == 0,
           $urandom_range(3) != 0);

    // asynchronous reset mid-clip
    step(1, 0, 0);
    run_to(2, 0);
    idle(1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_addr", 32'(rom_addr), 32'd0);
    chk("arst_sample", 32'(sample), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(sample_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_dac", 32'(dac_out), 32'd0);
    #2 rst_n = 1'b1;
    idle(12, 0);

`ifdef AUDIO_DSM_EN
    rom_hi = 1'b1;
    step(1, 0, 0);
    idle(40, 0);
    chk("hi_sample", 32'(sample), 32'h7FFF);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      step(0, 0, 0);
      ones += int'(dac_out);
    end
    chk("dsm_density", 32'(ones >= 4092), 32'd1);
`else
    ones = 0;
    chk("dsm_off", 32'(ones), 32'(dac_out));
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
